// File: rtl/eth_tx_mac.sv
// Transmit MAC stage: pops frame lengths and 64-bit data words from two
// first-word-fall-through FIFOs and serialises them MSB byte first onto a
// byte-wide GMII-style interface, framed by preamble, SFD, CRC-32 FCS and
// an inter-frame gap. A FIFO underrun aborts the frame with one tx_er
// cycle, then the rest of the frame's words are drained silently.
module eth_tx_mac #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ctl_rd_en_out,
    input  logic [15:0] ctl_rd_d_in,
    input  logic        ctl_rd_empty_in,
    output logic        data_rd_en_out,
    input  logic [63:0] data_rd_d_in,
    input  logic        data_rd_empty_in,
    output logic        tx_en_out,
    output logic        tx_er_out,
    output logic [7:0]  tx_d_out,
    output logic        underrun_out
);

    // ST_ERR is the single tx_er cycle that follows a missed pop; the
    // frame then continues into ST_DRAIN with the transmitter idle.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_FCS,
        ST_ERR,
        ST_DRAIN,
        ST_IFG
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES - 1);
    localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [6:0]  n_q, n_d;
    logic [6:0]  remain_q, remain_d;
    logic [63:0] shift_q, shift_d;
    logic [31:0] crc_q, crc_d;
    logic        underrun_q, underrun_d;
    logic        armed_q, armed_d;

    logic [31:0] fcs;
    logic [31:0] fcs_shift;
    logic        unused_ctl_bits;

    assign unused_ctl_bits = ^ctl_rd_d_in[15:7];

    // Reflected CRC-32 (poly 0xEDB88320), one byte consumed LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h000000, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // State register and datapath flops; armed_q holds off the first ctl pop until after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            n_q        <= 7'd0;
            remain_q   <= 7'd0;
            shift_q    <= 64'd0;
            crc_q      <= 32'hFFFFFFFF;
            underrun_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            remain_q   <= remain_d;
            shift_q    <= shift_d;
            crc_q      <= crc_d;
            underrun_q <= underrun_d;
            armed_q    <= armed_d;
        end
    end

    // Next-state, FIFO pop strobes and transmit outputs for each frame phase.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        n_d            = n_q;
        remain_d       = remain_q;
        shift_d        = shift_q;
        crc_d          = crc_q;
        underrun_d     = underrun_q;
        armed_d        = 1'b1;
        ctl_rd_en_out  = 1'b0;
        data_rd_en_out = 1'b0;
        tx_en_out      = 1'b0;
        tx_er_out      = 1'b0;
        tx_d_out       = 8'h00;
        fcs            = ~crc_q;
        fcs_shift      = fcs >> {cnt_q[1:0], 3'b000};

        case (state_q)
            ST_IDLE: begin
                if (armed_q && !ctl_rd_empty_in) begin
                    ctl_rd_en_out = 1'b1;
                    n_d           = ctl_rd_d_in[6:0];
                    if (ctl_rd_d_in[6:0] != 7'd0) begin
                        state_d = ST_PRE;
                        cnt_d   = 8'd0;
                    end
                end
            end
            ST_PRE: begin
                tx_en_out = 1'b1;
                tx_d_out  = 8'h55;
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_SFD;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SFD: begin
                tx_en_out = 1'b1;
                tx_d_out  = 8'hD5;
                crc_d     = 32'hFFFFFFFF;
                if (data_rd_empty_in) begin
                    underrun_d = 1'b1;
                    remain_d   = n_q;
                    state_d    = ST_ERR;
                end else begin
                    data_rd_en_out = 1'b1;
                    shift_d        = data_rd_d_in;
                    remain_d       = n_q - 7'd1;
                    state_d        = ST_DATA;
                    cnt_d          = 8'd0;
                end
            end
            ST_DATA: begin
                tx_en_out = 1'b1;
                tx_d_out  = shift_q[63:56];
                crc_d     = crc_byte(crc_q, shift_q[63:56]);
                shift_d   = shift_q << 8;
                if (cnt_q == 8'd7) begin
                    cnt_d = 8'd0;
                    if (remain_q == 7'd0) begin
                        state_d = ST_FCS;
                    end else if (data_rd_empty_in) begin
                        underrun_d = 1'b1;
                        state_d    = ST_ERR;
                    end else begin
                        data_rd_en_out = 1'b1;
                        shift_d        = data_rd_d_in;
                        remain_d       = remain_q - 7'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_FCS: begin
                tx_en_out = 1'b1;
                tx_d_out  = fcs_shift[7:0];
                if (cnt_q == 8'd3) begin
                    state_d = ST_IFG;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_ERR: begin
                tx_en_out = 1'b1;
                tx_er_out = 1'b1;
                state_d   = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!data_rd_empty_in) begin
                    data_rd_en_out = 1'b1;
                    remain_d       = remain_q - 7'd1;
                    if (remain_q == 7'd1) begin
                        state_d = ST_IFG;
                        cnt_d   = 8'd0;
                    end
                end
            end
            ST_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign underrun_out = underrun_q;

endmodule

// File: tb/tb_eth_tx_mac.sv
// Self-checking bench for eth_tx_mac: FWFT FIFO models feed the DUT, the
// stimulus side queues expected transmit bytes and frame lengths, and a
// negedge monitor pops and compares whatever the DUT transmits.
module tb_eth_tx_mac;

    localparam int PRE = 7;
    localparam int IFG = 12;
    localparam logic [63:0] CNT_PAT = 64'h0101010101010101;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ctl_rd_en_out;
    logic [15:0] ctl_rd_d_in = 16'h0;
    logic        ctl_rd_empty_in = 1'b1;
    logic        data_rd_en_out;
    logic [63:0] data_rd_d_in = 64'h0;
    logic        data_rd_empty_in = 1'b1;
    logic        tx_en_out;
    logic        tx_er_out;
    logic [7:0]  tx_d_out;
    logic        underrun_out;

    logic [15:0] ctl_fifo[$];
    logic [63:0] data_fifo[$];
    logic [63:0] frame_words[$];
    logic [8:0]  exp_q[$];
    int          exp_len_q[$];
    logic [7:0]  cap_q[$];
    int          pop_cyc[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ctl_pops = 0;
    int   data_pops = 0;
    int   frames_seen = 0;
    int   last_rise = 0;
    int   last_gap = 0;
    int   run_len = 0;
    int   idle_run = 0;
    bit   in_frame = 1'b0;
    bit   ctl_pend = 1'b0;
    bit   data_pend = 1'b0;
    int   base_ctl;
    int   base_data;
    logic [8:0]  mon_exp;
    logic [15:0] dummy16;
    logic [63:0] dummy64;

    always #5 clk = ~clk;

    eth_tx_mac #(
        .PREAMBLE_BYTES(PRE),
        .IFG_BYTES(IFG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctl_rd_en_out(ctl_rd_en_out),
        .ctl_rd_d_in(ctl_rd_d_in),
        .ctl_rd_empty_in(ctl_rd_empty_in),
        .data_rd_en_out(data_rd_en_out),
        .data_rd_d_in(data_rd_d_in),
        .data_rd_empty_in(data_rd_empty_in),
        .tx_en_out(tx_en_out),
        .tx_er_out(tx_er_out),
        .tx_d_out(tx_d_out),
        .underrun_out(underrun_out)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic refreshFifos();
        ctl_rd_empty_in  = (ctl_fifo.size() == 0);
        ctl_rd_d_in      = (ctl_fifo.size() != 0) ? ctl_fifo[0] : 16'h0;
        data_rd_empty_in = (data_fifo.size() == 0);
        data_rd_d_in     = (data_fifo.size() != 0) ? data_fifo[0] : 64'h0;
    endtask

    task automatic setWords(input int n, input logic [63:0] base, input logic [63:0] step);
        frame_words.delete();
        for (int k = 0; k < n; k++) frame_words.push_back(base + step * 64'(k));
    endtask

    // Queue a ctl word (junk in the ignored upper bits) plus frame_words, and the expected frame.
    task automatic applyStimulus(input int n);
        logic [31:0] crc;
        logic [63:0] w;
        logic [7:0]  b;
        ctl_fifo.push_back({9'h1A5, 7'(n)});
        foreach (frame_words[k]) data_fifo.push_back(frame_words[k]);
        if (n > 0) begin
            crc = 32'hFFFFFFFF;
            for (int i = 0; i < PRE; i++) exp_q.push_back({1'b0, 8'h55});
            exp_q.push_back({1'b0, 8'hD5});
            for (int k = 0; k < n; k++) begin
                w = frame_words[k];
                for (int j = 0; j < 8; j++) begin
                    b = w[63 - 8*j -: 8];
                    crc = crcStep(crc, b);
                    exp_q.push_back({1'b0, b});
                end
            end
            crc = ~crc;
            for (int j = 0; j < 4; j++) exp_q.push_back({1'b0, crc[8*j +: 8]});
            exp_len_q.push_back(PRE + 1 + 8*n + 4);
        end
    endtask

    task automatic waitExpEmpty(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp_len_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput(name, ok, 1);
    endtask

    task automatic waitDone(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp_len_q.size() == 0 && !tx_en_out &&
                ctl_fifo.size() == 0 && data_fifo.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput(name, ok, 1);
        repeat (IFG + 4) @(negedge clk);
    endtask

    // FWFT FIFO model: apply the pops seen in the previous cycle just after the edge.
    always begin
        @(posedge clk);
        #1;
        if (ctl_pend && ctl_fifo.size() != 0) dummy16 = ctl_fifo.pop_front();
        if (data_pend && data_fifo.size() != 0) dummy64 = data_fifo.pop_front();
        ctl_pend  = 1'b0;
        data_pend = 1'b0;
        refreshFifos();
    end

    // Monitor: record pops, compare every transmitted byte and every frame length.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            in_frame  = 1'b0;
            run_len   = 0;
            idle_run  = 0;
            ctl_pend  = 1'b0;
            data_pend = 1'b0;
        end else begin
            if (ctl_rd_en_out || data_rd_en_out)
                checkOutput("pop_exclusive", {63'h0, ctl_rd_en_out & data_rd_en_out}, 0);
            if (ctl_rd_en_out) begin
                checkOutput("ctl_pop_nonempty", {63'h0, ctl_fifo.size() != 0}, 1);
                ctl_pend = 1'b1;
                ctl_pops++;
            end
            if (data_rd_en_out) begin
                checkOutput("data_pop_nonempty", {63'h0, data_fifo.size() != 0}, 1);
                data_pend = 1'b1;
                data_pops++;
                pop_cyc.push_back(cyc);
            end
            if (tx_en_out) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    run_len  = 0;
                    if (frames_seen > 0) last_gap = idle_run;
                    last_rise = cyc;
                    frames_seen++;
                end
                run_len++;
                cap_q.push_back(tx_d_out);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_tx actual=%0h expected=none at cycle %0d", tx_d_out, cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("tx_byte", {55'h0, tx_er_out, tx_d_out}, {55'h0, mon_exp});
                end
            end else begin
                checkOutput("tx_idle", {55'h0, tx_er_out, tx_d_out}, 0);
                if (in_frame) begin
                    in_frame = 1'b0;
                    idle_run = 0;
                    if (exp_len_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL frame_len actual=%0d expected=none", run_len);
                    end else begin
                        checkOutput("frame_len", run_len, exp_len_q.pop_front());
                    end
                end
                idle_run++;
            end
        end
    end

    initial begin
        logic [31:0] res;
        logic [31:0] rev;

        // Reset state with a control word already waiting
        refreshFifos();
        repeat (3) @(negedge clk);
        setWords(8, CNT_PAT, CNT_PAT);
        applyStimulus(8);
        refreshFifos();
        @(negedge clk);
        checkOutput("reset_ctl_rd_en", ctl_rd_en_out, 0);
        checkOutput("reset_data_rd_en", data_rd_en_out, 0);
        checkOutput("reset_tx_en", tx_en_out, 0);
        checkOutput("reset_tx_er", tx_er_out, 0);
        checkOutput("reset_tx_d", tx_d_out, 0);
        checkOutput("reset_underrun", underrun_out, 0);

        // Basic N=8 frame
        base_ctl  = ctl_pops;
        base_data = data_pops;
        cap_q.delete();
        rst = 1'b1;
        waitDone(400, "frame8_done");
        checkOutput("frame8_ctl_pops", ctl_pops - base_ctl, 1);
        checkOutput("frame8_data_pops", data_pops - base_data, 8);
        checkOutput("frame8_tx_cycles", cap_q.size(), 76);

        // All-zero payload, plus receive-side residue over data and FCS
        cap_q.delete();
        setWords(8, 64'h0, 64'h0);
        applyStimulus(8);
        waitDone(400, "zero_frame_done");
        checkOutput("zero_tx_cycles", cap_q.size(), 76);
        res = 32'hFFFFFFFF;
        for (int i = PRE + 1; i < cap_q.size(); i++) res = crcStep(res, cap_q[i]);
        for (int i = 0; i < 32; i++) rev[i] = res[31 - i];
        checkOutput("crc_residue", rev, 32'hC704DD7B);

        // Back-to-back N=8 then N=9
        setWords(8, CNT_PAT, CNT_PAT);
        applyStimulus(8);
        setWords(9, CNT_PAT, CNT_PAT);
        applyStimulus(9);
        waitDone(800, "b2b_done");
        checkOutput("b2b_gap", last_gap, 13);

        // Zero-length control word followed by N=8
        base_ctl  = ctl_pops;
        base_data = data_pops;
        frame_words.delete();
        applyStimulus(0);
        setWords(8, 64'hFEDCBA9876543210, 64'h0102030405060708);
        applyStimulus(8);
        waitDone(400, "zero_n_done");
        checkOutput("zero_n_ctl_pops", ctl_pops - base_ctl, 2);
        checkOutput("zero_n_data_pops", data_pops - base_data, 8);

        // Underrun: N=8 with only three words available
        base_data = data_pops;
        ctl_fifo.push_back(16'h0008);
        for (int k = 0; k < 3; k++) data_fifo.push_back(CNT_PAT * 64'(k + 1));
        for (int i = 0; i < PRE; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 8; j++) exp_q.push_back({1'b0, 8'(k + 1)});
        exp_q.push_back({1'b1, 8'h00});
        exp_len_q.push_back(PRE + 1 + 24 + 1);
        waitExpEmpty(300, "underrun_frame_done");
        checkOutput("underrun_flag", underrun_out, 1);
        repeat (20) @(negedge clk);
        checkOutput("underrun_stalled_pops", data_pops - base_data, 3);
        checkOutput("underrun_sticky", underrun_out, 1);
        for (int k = 3; k < 8; k++) data_fifo.push_back(CNT_PAT * 64'(k + 1));
        setWords(1, 64'hA5A55A5A0F0FF0F0, 64'h0);
        applyStimulus(1);
        waitDone(400, "underrun_drain_done");
        checkOutput("underrun_total_pops", data_pops - base_data, 9);
        checkOutput("drain_to_next_frame", last_rise - pop_cyc[base_data + 7], 14);
        checkOutput("underrun_sticky_after", underrun_out, 1);

        // Reset asserted in the middle of DATA, then a clean frame
        base_data = data_pops;
        setWords(8, CNT_PAT, CNT_PAT);
        applyStimulus(8);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (data_pops - base_data >= 3) break;
        end
        checkOutput("reset_reach_data", {63'h0, data_pops - base_data >= 3}, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("midreset_tx_en", tx_en_out, 0);
        checkOutput("midreset_tx_er", tx_er_out, 0);
        checkOutput("midreset_tx_d", tx_d_out, 0);
        checkOutput("midreset_ctl_rd_en", ctl_rd_en_out, 0);
        checkOutput("midreset_data_rd_en", data_rd_en_out, 0);
        checkOutput("midreset_underrun", underrun_out, 0);
        exp_q.delete();
        exp_len_q.delete();
        ctl_fifo.delete();
        data_fifo.delete();
        refreshFifos();
        repeat (3) @(negedge clk);
        base_ctl  = ctl_pops;
        base_data = data_pops;
        cap_q.delete();
        setWords(8, 64'h0011223344556677, 64'h1111111111111111);
        applyStimulus(8);
        rst = 1'b1;
        waitDone(400, "after_reset_done");
        checkOutput("after_reset_ctl_pops", ctl_pops - base_ctl, 1);
        checkOutput("after_reset_data_pops", data_pops - base_data, 8);
        checkOutput("after_reset_tx_cycles", cap_q.size(), 76);
        checkOutput("after_reset_underrun", underrun_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_mac.md
Name: eth_tx_mac

Overview:
- Transmit MAC stage. It sits directly downstream of the frame encoder's data and control FIFOs.
- Each control word gives a frame length in 64-bit words. The block pops that many data words and serialises them MSB byte first onto a byte-wide GMII-style transmit interface.
- It adds preamble, SFD, IEEE 802.3 CRC-32 FCS and the inter-frame gap.

Parameters:
- PREAMBLE_BYTES, 7, number of 0x55 bytes before the SFD.
- IFG_BYTES, 12, minimum number of tx_en_out=0 cycles after the last FCS byte.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset: asserted while rst=0, released on rst=1.
- ctl_rd_en_out  out  1  one-cycle pop strobe to the control FIFO.
- ctl_rd_d_in  in  16  control word; [6:0] is the word count N, [15:7] is ignored.
- ctl_rd_empty_in  in  1  control FIFO empty.
- data_rd_en_out  out  1  one-cycle pop strobe to the data FIFO.
- data_rd_d_in  in  64  data word; byte [63:56] is sent first.
- data_rd_empty_in  in  1  data FIFO empty.
- tx_en_out  out  1  transmit enable.
- tx_er_out  out  1  transmit error (underrun).
- tx_d_out  out  8  transmit byte.
- underrun_out  out  1  sticky underrun flag, cleared only by reset.

Behaviour:
- Both FIFOs are first-word-fall-through: d_in is valid whenever empty=0. A pop is rd_en=1 for one cycle with empty=0. The block never pops an empty FIFO.
- Reset values: every output 0; state IDLE; CRC register 0xFFFFFFFF; counters 0.
- States: IDLE, PRE, SFD, DATA, FCS, DRAIN, IFG.
- IDLE:
  - If ctl_rd_empty_in=0: pulse ctl_rd_en_out, latch N=ctl_rd_d_in[6:0].
  - If N=0: pop and discard the word, stay in IDLE.
  - Otherwise go to PRE.
- PRE: PREAMBLE_BYTES cycles of tx_en_out=1, tx_d_out=0x55. The first preamble byte is on the cycle after the ctl pop.
- SFD: one cycle of tx_d_out=0xD5.
  - Same cycle: pop data word 0 into a 64-bit shift register and initialise the CRC to 0xFFFFFFFF.
- DATA: N*8 cycles, byte order [63:56] down to [7:0].
  - On the cycle emitting byte [7:0] of word k (k<N-1), pop word k+1.
  - Each emitted byte updates the CRC: reflected polynomial 0xEDB88320, LSB-first per byte.
- FCS: 4 cycles sending ~CRC, bits [7:0] first, then [15:8], [23:16], [31:24].
- IFG: IFG_BYTES cycles of tx_en_out=0, tx_d_out=0, then IDLE.
  - Minimum gap between frames is IFG_BYTES+1 idle cycles (including the IDLE pop cycle).
- tx_en_out stays 1 continuously from the first preamble byte to the last FCS byte, i.e. 8+N*8+4 cycles with default parameters.
- Underrun: data_rd_empty_in=1 at a required pop point (SFD or last byte of a word).
  - That cycle: tx_en_out=1, tx_er_out=1, tx_d_out=0; set underrun_out.
  - Then DRAIN: tx_en_out=0 and pop the remaining words of the frame as they become available, including the missed one. Then IFG.
- tx_er_out is 1 only on the underrun cycle.
- Reset mid-frame: all outputs go to 0 immediately (asynchronous). No partial FCS is sent.
- ctl_rd_en_out and data_rd_en_out are never high in the same cycle.

Test Plan:
- Word count N=8, data words W0..W7 = 0x0101010101010101*(k+1), both FIFOs preloaded:
  - ctl_rd_en_out pulses once, then tx_en_out=1 for exactly 76 consecutive cycles.
  - Bytes 1-7 = 0x55, byte 8 = 0xD5, bytes 9-16 = 0x01, ..., bytes 65-72 = 0x08.
  - Last 4 bytes match a software CRC-32 of the 64 data bytes, LSB first.
  - Exactly 8 data_rd_en_out pulses.
- CRC sanity: frame containing the 64 bytes 0x00 -> FCS bytes match the software model. Also check the receive-side residue: CRC over data+FCS equals 0xC704DD7B.
- Back-to-back: two ctl words (N=8, N=9) queued:
  - Exactly 13 cycles of tx_en_out=0 between the frames.
  - Second frame is 84 tx_en_out cycles.
- N=0 control word followed by N=8: the zero entry is popped with no tx activity and no data pop; the next frame is sent normally.
- Underrun: ctl N=8, data FIFO holds only 3 words:
  - tx_er_out=1 on the cycle after word 2's last byte; underrun_out=1 and stays 1.
  - Remaining 5 words, supplied later, are popped with tx_en_out=0, followed by an IFG of 12 cycles.
- Reset: drive rst=0 mid-DATA -> all outputs 0 the same cycle. After release with N=8 queued, a correct 76-cycle frame is sent.
